// File: rtl/dmem_port.sv
// dmem_port: multi-cycle data-memory responder for the core's load/store path.
// Latency: response registered LATENCY+1 edges after request acceptance.
// Backpressure: one request outstanding; req_ready low until the response is taken.
// Ports: clk/reset (async, active-high); req_valid/req_ready/req_we/req_size/
//   req_addr/req_wdata request channel; resp_valid/resp_ready/resp_rdata/resp_err
//   response channel. req_size uses RISC-V funct3 (B,H,W,BU,HU).
module dmem_port #(
  parameter int AW      = 18,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state_q;
  logic [3:0]    cnt_q;
  logic          we_q;
  logic [2:0]    size_q;
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q;
  logic          req_ready_q;
  logic          resp_valid_q;
  logic [31:0]   rdata_q;
  logic          err_q;

  // Array is deliberately not reset.
  logic [31:0]   mem [0:(1<<AW)-1];

  // Address bits above the word index alias onto the array.
  logic          unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:AW+2];

  logic          commit;
  logic          illegal;
  logic          misal;
  logic          err_d;
  logic [31:0]   rdata_d;
  logic [31:0]   mem_word;
  logic [31:0]   byte_sh;
  logic [31:0]   half_sh;
  logic [3:0]    be_d;
  logic [31:0]   wword_d;
  logic          wr_en;

  // The counter counts down the wait states; the commit edge is the one after
  // it has reached zero, so the response lands LATENCY+1 edges after acceptance.
  assign commit = (state_q == WAIT) && (cnt_q == 4'd0);

  always_comb begin
    illegal  = (size_q == 3'b011) || (size_q == 3'b110) || (size_q == 3'b111) ||
               (we_q && size_q[2]);
    misal    = ((size_q[1:0] == 2'b01) && addr_q[0]) ||
               ((size_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
    err_d    = illegal || misal;
    mem_word = mem[addr_q[AW+1:2]];
    byte_sh  = mem_word >> {addr_q[1:0], 3'b000};
    half_sh  = mem_word >> {addr_q[1], 4'b0000};
    rdata_d  = 32'd0;
    be_d     = 4'b0000;
    wword_d  = wdata_q;
    case (size_q)
      3'b000: begin
        rdata_d = {{24{byte_sh[7]}}, byte_sh[7:0]};
        be_d    = 4'b0001 << addr_q[1:0];
        wword_d = {4{wdata_q[7:0]}};
      end
      3'b001: begin
        rdata_d = {{16{half_sh[15]}}, half_sh[15:0]};
        be_d    = 4'b0011 << {addr_q[1], 1'b0};
        wword_d = {2{wdata_q[15:0]}};
      end
      3'b010: begin
        rdata_d = mem_word;
        be_d    = 4'b1111;
      end
      3'b100:  rdata_d = {24'd0, byte_sh[7:0]};
      3'b101:  rdata_d = {16'd0, half_sh[15:0]};
      default: rdata_d = 32'd0;
    endcase
    if (err_d || we_q) rdata_d = 32'd0;
    wr_en = commit && we_q && !err_d;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (be_d[0]) mem[addr_q[AW+1:2]][7:0]   <= wword_d[7:0];
      if (be_d[1]) mem[addr_q[AW+1:2]][15:8]  <= wword_d[15:8];
      if (be_d[2]) mem[addr_q[AW+1:2]][23:16] <= wword_d[23:16];
      if (be_d[3]) mem[addr_q[AW+1:2]][31:24] <= wword_d[31:24];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      we_q         <= 1'b0;
      size_q       <= 3'd0;
      addr_q       <= '0;
      wdata_q      <= 32'd0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      rdata_q      <= 32'd0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q        <= req_we;
            size_q      <= req_size;
            addr_q      <= req_addr[AW+1:0];
            wdata_q     <= req_wdata;
            cnt_q       <= 4'(LATENCY);
            req_ready_q <= 1'b0;
            state_q     <= WAIT;
          end
        end
        WAIT: begin
          if (commit) begin
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          // Returning to IDLE here means the next request is taken no earlier
          // than the edge after the response handshake.
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_port.sv
module tb_dmem_port;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_we     [2];
  logic [2:0]  req_size   [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];

  int checks   = 0;
  int failures = 0;
  logic [32:0] sb_q [$];

  localparam logic [2:0] SZ_B = 3'b000, SZ_H = 3'b001, SZ_W = 3'b010,
                         SZ_BU = 3'b100, SZ_HU = 3'b101;

  dmem_port #(.AW(18), .LATENCY(2)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_size(req_size[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
  );

  dmem_port #(.AW(10), .LATENCY(0)) u_dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_size(req_size[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic scramble(input int s);
    req_we[s]    = 1'($urandom);
    req_size[s]  = 3'($urandom);
    req_addr[s]  = $urandom;
    req_wdata[s] = $urandom;
  endtask

  // One transaction with latency, issue-interval and scoreboard checks.
  // hold = cycles resp_ready stays low in RESP while req_* are toggled.
  task automatic do_req(input int s, input logic we, input logic [2:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata_exp, input logic err_exp,
                        input int hold);
    int edges;
    int low;
    int l;
    logic [32:0] e;
    logic [31:0] held_d;
    logic        held_e;
    l = (s == 0) ? 2 : 0;
    chk("req_ready_idle", req_ready[s], 1);
    req_we[s] = we; req_size[s] = size; req_addr[s] = addr; req_wdata[s] = wdata;
    req_valid[s] = 1'b1;
    sb_q.push_back({err_exp, rdata_exp});
    step;                               // acceptance edge T0
    req_valid[s] = 1'b0;
    scramble(s);
    low = 0;
    if (!req_ready[s]) low++;
    edges = 0;
    while (!resp_valid[s] && edges < 40) begin
      step;
      edges++;
      if (!req_ready[s]) low++;
      scramble(s);
    end
    chk("resp_latency", edges, l + 1);
    held_d = resp_rdata[s];
    held_e = resp_err[s];
    for (int i = 0; i < hold; i++) begin
      req_valid[s] = 1'($urandom);
      scramble(s);
      step;
      if (!req_ready[s]) low++;
      chk("hold_valid", resp_valid[s], 1);
      chk("hold_rdata", resp_rdata[s], held_d);
      chk("hold_err", resp_err[s], held_e);
      chk("hold_req_ready", req_ready[s], 0);
    end
    req_valid[s]  = 1'b0;
    resp_ready[s] = 1'b1;
    if (sb_q.size() == 0) begin
      chk("sb_nonempty", 0, 1);
    end else begin
      e = sb_q.pop_front();
      chk("resp_rdata", resp_rdata[s], e[31:0]);
      chk("resp_err", resp_err[s], e[32]);
    end
    step;                               // response handshake edge
    resp_ready[s] = 1'b0;
    chk("resp_valid_drop", resp_valid[s], 0);
    chk("req_ready_back", req_ready[s], 1);
    chk("issue_interval", low, l + 2 + hold);
    if (hold > 0) begin
      for (int i = 0; i < 3; i++) begin
        step;
        chk("single_resp", resp_valid[s], 0);
      end
    end
  endtask

  // Store that is aborted by reset while still waiting to commit.
  task automatic rst_store(input int s, input logic [31:0] addr, input logic [31:0] wdata);
    req_we[s] = 1'b1; req_size[s] = SZ_W; req_addr[s] = addr; req_wdata[s] = wdata;
    req_valid[s] = 1'b1;
    step;
    req_valid[s] = 1'b0;
    chk("wait_req_ready", req_ready[s], 0);
    #2 reset = 1'b1;
    #1;
    chk("rst_resp_valid", resp_valid[s], 0);
    chk("rst_req_ready", req_ready[s], 1);
    chk("rst_rdata", resp_rdata[s], 0);
    chk("rst_err", resp_err[s], 0);
    #1 reset = 1'b0;
    step;
    chk("post_rst_resp_valid", resp_valid[s], 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_we[i] = 1'b0; req_size[i] = 3'd0;
      req_addr[i] = 32'd0; req_wdata[i] = 32'd0; resp_ready[i] = 1'b0;
    end
    #2;
    for (int i = 0; i < 2; i++) begin
      chk("reset_req_ready", req_ready[i], 1);
      chk("reset_resp_valid", resp_valid[i], 0);
      chk("reset_rdata", resp_rdata[i], 0);
      chk("reset_err", resp_err[i], 0);
    end
    step;
    reset = 1'b0;
    step;

    // LATENCY=2 instance
    do_req(0, 1, SZ_W,  32'h100, 32'hDEADBEEF, 32'h0,        0, 0);
    do_req(0, 0, SZ_W,  32'h100, 32'h0,        32'hDEADBEEF, 0, 0);
    do_req(0, 1, SZ_B,  32'h103, 32'h00000080, 32'h0,        0, 0);
    do_req(0, 0, SZ_B,  32'h103, 32'h0,        32'hFFFFFF80, 0, 0);
    do_req(0, 0, SZ_BU, 32'h103, 32'h0,        32'h00000080, 0, 0);
    do_req(0, 0, SZ_W,  32'h100, 32'h0,        32'h80ADBEEF, 0, 0);
    do_req(0, 1, SZ_H,  32'h102, 32'h00008001, 32'h0,        0, 0);
    do_req(0, 0, SZ_H,  32'h102, 32'h0,        32'hFFFF8001, 0, 0);
    do_req(0, 0, SZ_HU, 32'h102, 32'h0,        32'h00008001, 0, 0);
    do_req(0, 0, SZ_H,  32'h101, 32'h0,        32'h0,        1, 0);
    do_req(0, 0, SZ_W,  32'h100, 32'h0,        32'h8001BEEF, 0, 0);
    do_req(0, 1, SZ_W,  32'h200, 32'hCAFEF00D, 32'h0,        0, 0);
    do_req(0, 1, SZ_W,  32'h202, 32'h12345678, 32'h0,        1, 0);
    do_req(0, 0, SZ_W,  32'h200, 32'h0,        32'hCAFEF00D, 0, 0);
    do_req(0, 0, 3'b011, 32'h200, 32'h0,       32'h0,        1, 0);
    do_req(0, 1, SZ_BU, 32'h200, 32'h000000FF, 32'h0,        1, 0);
    do_req(0, 0, SZ_W,  32'h200, 32'h0,        32'hCAFEF00D, 0, 0);
    do_req(0, 0, SZ_W,  32'h0010_0100, 32'h0,  32'h8001BEEF, 0, 0);
    do_req(0, 0, SZ_W,  32'h200, 32'h0,        32'hCAFEF00D, 0, 5);
    do_req(0, 1, SZ_W,  32'h300, 32'h11112222, 32'h0,        0, 0);
    rst_store(0, 32'h300, 32'h99999999);
    do_req(0, 0, SZ_W,  32'h300, 32'h0,        32'h11112222, 0, 0);

    // LATENCY=0 instance
    do_req(1, 1, SZ_W,  32'h300, 32'hAAAA5555, 32'h0,        0, 0);
    do_req(1, 0, SZ_W,  32'h300, 32'h0,        32'hAAAA5555, 0, 0);
    do_req(1, 0, SZ_B,  32'h301, 32'h0,        32'h00000055, 0, 0);
    do_req(1, 0, SZ_H,  32'h302, 32'h0,        32'hFFFFAAAA, 0, 0);
    rst_store(1, 32'h300, 32'h12121212);
    do_req(1, 0, SZ_W,  32'h300, 32'h0,        32'hAAAA5555, 0, 0);

    chk("sb_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
